q294_layer_serial: RTL and testbench

Registered, nibble-serial application of the 3-share threshold implementation of the quadratic Q294 layer to a full 64-bit Midori64 state. It accepts a 3-share state over a valid/ready handshake and processes NPC nibbles per cycle through 3·NPC share-component instances. Results land in a share register, which is the glitch-stopping register required between nonlinear TI stages. The result is presented downstream over a second valid/ready handshake. The block sits between the previous round's linear layer and the next stage of the shared S-box decomposition.

---
 rtl/q294_pkg.sv | 22 ++
 rtl/q294_layer_serial_if.sv | 25 ++
 rtl/q294_nibble_ti.sv | 17 +
 rtl/q294_layer_serial.sv | 113 +++++++++++
 tb/tb_q294_layer_serial.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/q294_pkg.sv
// Shared types and the single-share Q294 threshold component for the nibble-serial layer.
package q294_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int NIBBLES = 16;

    // a is this share's nibble, b is the next share's nibble in the rotation.
    function automatic logic [3:0] q294_share(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] o;
        o[3] = a[3];
        o[2] = a[2];
        o[1] = a[1] ^ (a[3] & a[2]) ^ (a[3] & b[2]) ^ (b[3] & a[2]);
        o[0] = a[0] ^ (a[3] & a[1]) ^ (a[3] & b[1]) ^ (b[3] & a[1]);
        return o;
    endfunction

endpackage

// File: rtl/q294_layer_serial_if.sv
// Input/output valid-ready bus carrying the three 64-bit shares of a Midori64 state.
interface q294_layer_serial_if;

    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_sh1;
    logic [63:0] in_sh2;
    logic [63:0] in_sh3;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_sh1;
    logic [63:0] out_sh2;
    logic [63:0] out_sh3;

    modport master (
        output in_valid, in_sh1, in_sh2, in_sh3, out_ready,
        input  in_ready, out_valid, out_sh1, out_sh2, out_sh3
    );

    modport slave (
        input  in_valid, in_sh1, in_sh2, in_sh3, out_ready,
        output in_ready, out_valid, out_sh1, out_sh2, out_sh3
    );

endinterface

// File: rtl/q294_nibble_ti.sv
// Combinational 3-share Q294 for one nibble; each output share is non-complete (never sees its own "previous" share).
module q294_nibble_ti
    import q294_pkg::*;
(
    input  logic [3:0] i_sh1,
    input  logic [3:0] i_sh2,
    input  logic [3:0] i_sh3,
    output logic [3:0] o_sh1,
    output logic [3:0] o_sh2,
    output logic [3:0] o_sh3
);

    assign o_sh1 = q294_share(i_sh1, i_sh2);
    assign o_sh2 = q294_share(i_sh2, i_sh3);
    assign o_sh3 = q294_share(i_sh3, i_sh1);

endmodule

// File: rtl/q294_layer_serial.sv
// Nibble-serial Q294 TI layer: loads a shared state, rotates it through NPC component slices, presents the result.
module q294_layer_serial
    import q294_pkg::*;
#(
    parameter int NPC = 4
) (
    input  logic               clk,
    input  logic               rst,
    q294_layer_serial_if.slave bus,
    output logic               busy
);

    localparam int N  = NIBBLES / NPC;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = 4 * NPC;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [63:0]   r_sh1;
    logic [63:0]   r_sh2;
    logic [63:0]   r_sh3;
    logic          r_in_ready;
    logic          r_out_valid;
    logic          r_busy;

    logic [SW-1:0] w_new1;
    logic [SW-1:0] w_new2;
    logic [SW-1:0] w_new3;
    logic [63:0]   w_next1;
    logic [63:0]   w_next2;
    logic [63:0]   w_next3;

    for (genvar k = 0; k < NPC; k++) begin : g_nib
        q294_nibble_ti u_ti (
            .i_sh1 (r_sh1[4*k +: 4]),
            .i_sh2 (r_sh2[4*k +: 4]),
            .i_sh3 (r_sh3[4*k +: 4]),
            .o_sh1 (w_new1[4*k +: 4]),
            .o_sh2 (w_new2[4*k +: 4]),
            .o_sh3 (w_new3[4*k +: 4])
        );
    end

    // Results enter at the top so that after N shifts every nibble is back in its own position.
    if (NPC == NIBBLES) begin : g_full
        assign w_next1 = w_new1;
        assign w_next2 = w_new2;
        assign w_next3 = w_new3;
    end else begin : g_part
        assign w_next1 = {w_new1, r_sh1[63:SW]};
        assign w_next2 = {w_new2, r_sh2[63:SW]};
        assign w_next3 = {w_new3, r_sh3[63:SW]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_sh1       <= '0;
            r_sh2       <= '0;
            r_sh3       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_sh1      <= bus.in_sh1;
                        r_sh2      <= bus.in_sh2;
                        r_sh3      <= bus.in_sh3;
                        r_cnt      <= '0;
                        r_state    <= RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                RUN: begin
                    r_sh1 <= w_next1;
                    r_sh2 <= w_next2;
                    r_sh3 <= w_next3;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(N - 1)) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sh1   = r_sh1;
    assign bus.out_sh2   = r_sh2;
    assign bus.out_sh3   = r_sh3;
    assign busy          = r_busy;

endmodule

// File: tb/tb_q294_layer_serial.sv
// Directed bench driving NPC=1, 4 and 16 instances in lockstep from one shared input bus.
module tb_q294_layer_serial;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        inValid;
    logic        outReady;
    logic [63:0] inSh1;
    logic [63:0] inSh2;
    logic [63:0] inSh3;

    logic [2:0]  obsReady;
    logic [2:0]  obsValid;
    logic [2:0]  obsBusy;
    logic [63:0] obsSh1 [3];
    logic [63:0] obsSh2 [3];
    logic [63:0] obsSh3 [3];

    // Index 0: NPC=1, index 1: NPC=4, index 2: NPC=16.
    localparam int NV [3] = '{16, 4, 1};
    localparam logic [3:0] Q_TAB [16] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                                          4'h8, 4'h9, 4'hB, 4'hA, 4'hE, 4'hF, 4'hD, 4'hC};

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int P = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
        q294_layer_serial_if busI ();
        assign busI.in_valid  = inValid;
        assign busI.in_sh1    = inSh1;
        assign busI.in_sh2    = inSh2;
        assign busI.in_sh3    = inSh3;
        assign busI.out_ready = outReady;
        assign obsReady[g]    = busI.in_ready;
        assign obsValid[g]    = busI.out_valid;
        assign obsSh1[g]      = busI.out_sh1;
        assign obsSh2[g]      = busI.out_sh2;
        assign obsSh3[g]      = busI.out_sh3;
        q294_layer_serial #(.NPC(P)) u_dut (
            .clk  (clk),
            .rst  (rst),
            .bus  (busI),
            .busy (obsBusy[g])
        );
    end

    int errors = 0;
    int checks = 0;

    function automatic logic [63:0] qWord(input logic [63:0] x);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) r[4*k +: 4] = Q_TAB[x[4*k +: 4]];
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdleZero(input string tag);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("%s_rdy%0d", tag, i), 64'(obsReady[i]), 64'd1);
            checkOutput($sformatf("%s_vld%0d", tag, i), 64'(obsValid[i]), 64'd0);
            checkOutput($sformatf("%s_bsy%0d", tag, i), 64'(obsBusy[i]), 64'd0);
            checkOutput($sformatf("%s_sh1_%0d", tag, i), obsSh1[i], 64'd0);
            checkOutput($sformatf("%s_sh2_%0d", tag, i), obsSh2[i], 64'd0);
            checkOutput($sformatf("%s_sh3_%0d", tag, i), obsSh3[i], 64'd0);
        end
    endtask

    // One transaction into all three instances; latency and results are checked per instance.
    task automatic applyStimulus(input string tag, input logic [63:0] s1, input logic [63:0] s2,
                                 input logic [63:0] s3, input logic [63:0] e1, input logic [63:0] e2,
                                 input logic [63:0] e3, input bit xorOnly);
        int          lat [3];
        logic [63:0] c1 [3];
        logic [63:0] c2 [3];
        logic [63:0] c3 [3];
        for (int i = 0; i < 3; i++) begin
            lat[i] = -1;
            c1[i] = 'x; c2[i] = 'x; c3[i] = 'x;
            checkOutput($sformatf("%s_rdy%0d", tag, i), 64'(obsReady[i]), 64'd1);
        end
        inSh1 = s1; inSh2 = s2; inSh3 = s3;
        inValid = 1'b1;
        step();
        inValid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < 3; i++) begin
                if (obsValid[i] && lat[i] < 0) begin
                    lat[i] = k;
                    c1[i] = obsSh1[i]; c2[i] = obsSh2[i]; c3[i] = obsSh3[i];
                end
            end
            if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
            step();
        end
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("%s_lat%0d", tag, i), 64'(lat[i]), 64'(NV[i]));
            if (xorOnly) begin
                checkOutput($sformatf("%s_xor%0d", tag, i), c1[i] ^ c2[i] ^ c3[i], qWord(s1 ^ s2 ^ s3));
            end else begin
                checkOutput($sformatf("%s_sh1_%0d", tag, i), c1[i], e1);
                checkOutput($sformatf("%s_sh2_%0d", tag, i), c2[i], e2);
                checkOutput($sformatf("%s_sh3_%0d", tag, i), c3[i], e3);
            end
        end
        step();
    endtask

    localparam logic [63:0] XP = 64'h0123456789ABCDEF;
    localparam logic [63:0] QP = 64'h0123456789BAEFDC;
    localparam logic [63:0] H8 = 64'h8888888888888888;
    localparam logic [63:0] H4 = 64'h4444444444444444;
    localparam logic [63:0] HA = 64'hAAAAAAAAAAAAAAAA;

    logic [63:0] bbIn1 [3];
    logic [63:0] bbIn2 [3];
    logic [63:0] bbIn3 [3];
    logic [63:0] bbEx1 [3];
    logic [63:0] bbEx2 [3];
    logic [63:0] bbEx3 [3];

    initial begin
        int j;
        int r;
        rst = 1'b1; inValid = 1'b0; outReady = 1'b1;
        inSh1 = '0; inSh2 = '0; inSh3 = '0;
        step();
        checkIdleZero("reset");
        rst = 1'b0;
        step();

        applyStimulus("v1", 64'hF, 64'h0, 64'h0, 64'hC, 64'h0, 64'h0, 1'b0);
        applyStimulus("v2", 64'h8, 64'h4, 64'h0, 64'hA, 64'h4, 64'h0, 1'b0);
        applyStimulus("v3", XP, 64'h0, 64'h0, QP, 64'h0, 64'h0, 1'b0);
        applyStimulus("v4", 64'h0, XP, 64'h0, 64'h0, QP, 64'h0, 1'b0);
        applyStimulus("v4b", 64'h0, 64'h0, XP, 64'h0, 64'h0, QP, 1'b0);
        applyStimulus("v5", H8, H4, 64'h0, HA, H4, 64'h0, 1'b0);
        applyStimulus("v6", 64'h0, H8, H4, 64'h0, HA, H4, 1'b0);
        applyStimulus("v7", 64'h2000000000000002, 64'h8000000000000008, 64'h0,
                      64'h3000000000000003, 64'h8000000000000008, 64'h0, 1'b0);
        applyStimulus("v8", H4, 64'h0, H8, H4, 64'h0, HA, 1'b0);
        for (int n = 0; n < 8; n++) begin
            applyStimulus($sformatf("rnd%0d", n), {$urandom, $urandom}, {$urandom, $urandom},
                          {$urandom, $urandom}, 64'h0, 64'h0, 64'h0, 1'b1);
        end

        // Backpressure: every instance parks in DONE while in_valid pulses with junk.
        outReady = 1'b0;
        inSh1 = H8; inSh2 = H4; inSh3 = 64'h0;
        inValid = 1'b1;
        step();
        inValid = 1'b0;
        for (int k = 0; k < 16; k++) step();
        for (int c = 0; c < 10; c++) begin
            inValid = c[0];
            inSh1 = {$urandom, $urandom}; inSh2 = {$urandom, $urandom}; inSh3 = {$urandom, $urandom};
            step();
            for (int i = 0; i < 3; i++) begin
                checkOutput($sformatf("bp%0d_vld%0d", c, i), 64'(obsValid[i]), 64'd1);
                checkOutput($sformatf("bp%0d_rdy%0d", c, i), 64'(obsReady[i]), 64'd0);
                checkOutput($sformatf("bp%0d_bsy%0d", c, i), 64'(obsBusy[i]), 64'd1);
                checkOutput($sformatf("bp%0d_sh1_%0d", c, i), obsSh1[i], HA);
                checkOutput($sformatf("bp%0d_sh2_%0d", c, i), obsSh2[i], H4);
                checkOutput($sformatf("bp%0d_sh3_%0d", c, i), obsSh3[i], 64'h0);
            end
        end
        inValid = 1'b0;
        outReady = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("bprel_vld%0d", i), 64'(obsValid[i]), 64'd0);
            checkOutput($sformatf("bprel_rdy%0d", i), 64'(obsReady[i]), 64'd1);
        end

        // Reset while the NPC=1 instance is mid-RUN.
        inSh1 = XP; inSh2 = H4; inSh3 = H8;
        inValid = 1'b1;
        step();
        inValid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            checkOutput($sformatf("rr_vld_k%0d", k), 64'(obsValid[0]), 64'd0);
            if (k < 6) step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkIdleZero("rr");
        applyStimulus("rr_fresh", 64'h2000000000000002, 64'h8000000000000008, 64'h0,
                      64'h3000000000000003, 64'h8000000000000008, 64'h0, 1'b0);

        // Back-to-back on NPC=4: in_valid and out_ready held high.
        bbIn1 = '{XP, 64'h0, 64'h2000000000000002};
        bbIn2 = '{64'h0, H8, 64'h8000000000000008};
        bbIn3 = '{64'h0, H4, 64'h0};
        bbEx1 = '{QP, 64'h0, 64'h3000000000000003};
        bbEx2 = '{64'h0, HA, 64'h8000000000000008};
        bbEx3 = '{64'h0, H4, 64'h0};
        j = 0;
        r = 0;
        inValid = 1'b1;
        for (int k = 0; k < 30 && r < 3; k++) begin
            if (obsValid[1]) begin
                checkOutput($sformatf("bb%0d_time", r), 64'(k), 64'(6 * r + 5));
                checkOutput($sformatf("bb%0d_sh1", r), obsSh1[1], bbEx1[r]);
                checkOutput($sformatf("bb%0d_sh2", r), obsSh2[1], bbEx2[r]);
                checkOutput($sformatf("bb%0d_sh3", r), obsSh3[1], bbEx3[r]);
                r++;
            end
            if (obsReady[1]) begin
                checkOutput($sformatf("bb%0d_acc", j), 64'(k), 64'(6 * j));
                if (j < 3) begin
                    inSh1 = bbIn1[j]; inSh2 = bbIn2[j]; inSh3 = bbIn3[j];
                end
                j++;
            end
            step();
        end
        checkOutput("bb_results", 64'(r), 64'd3);
        inValid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
